washer_plant_model: RTL and testbench

- Appliance-side responder for the washing-machine controller FSM.
- Consumes the controller's actuator commands (fill valve, drain valve, motor, soap phase, door lock).
- Produces the sensor and timer signals the controller waits on: filled, drained, detergent, cycletime_out, spintime_out, doorclose.
- Used as the closed-loop plant in simulation and as the sensor/timer front end on FPGA builds.

---
 rtl/washer_plant_model.sv | 129 ++++++++++++
 tb/tb_washer_plant_model.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/washer_plant_model.sv
// Appliance-side plant for the washer controller: water level, cycle/spin timers,
// detergent dispenser, door sensor and a sticky fault flag.
module washer_plant_model #(
  parameter int LEVEL_W     = 8,
  parameter int LEVEL_MAX   = 200,
  parameter int FILL_STEP   = 4,
  parameter int DRAIN_STEP  = 5,
  parameter int TIMER_W     = 16,
  parameter int CYCLE_TICKS = 1000,
  parameter int SPIN_TICKS  = 500,
  parameter int DET_TICKS   = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fillvalve_on,
  input  logic               drainvalve_on,
  input  logic               motor_on,
  input  logic               soap_wash,
  input  logic               doorlock,
  input  logic               user_door_close,
  input  logic               user_door_open,
  output logic               filled,
  output logic               drained,
  output logic               detergent,
  output logic               cycletime_out,
  output logic               spintime_out,
  output logic               doorclose,
  output logic [LEVEL_W-1:0] level,
  output logic               fault
);

  // Dispenser states
  //   state    | meaning
  //   IDLE     | waiting for soap request with a full tank
  //   DISPENSE | counting DET_TICKS clocks of dispensing
  //   DONE     | detergent delivered, held until soap request drops
  typedef enum logic [1:0] {IDLE, DISPENSE, DONE} det_state_t;

  localparam int LW1 = LEVEL_W + 1;
  localparam logic [LEVEL_W:0]   L_MAX    = LW1'(LEVEL_MAX);
  localparam logic [LEVEL_W:0]   L_FILL   = LW1'(FILL_STEP);
  localparam logic [LEVEL_W:0]   L_DRAIN  = LW1'(DRAIN_STEP);
  localparam logic [TIMER_W-1:0] CYC_LAST = TIMER_W'(CYCLE_TICKS - 1);
  localparam logic [TIMER_W-1:0] SPN_LAST = TIMER_W'(SPIN_TICKS - 1);
  localparam logic [TIMER_W-1:0] DET_LAST = TIMER_W'(DET_TICKS - 1);

  logic [LEVEL_W:0]   lvl_wide, lvl_up, lvl_nxt;
  logic [TIMER_W-1:0] cyc_cnt, spn_cnt, det_cnt;
  det_state_t         state, state_nxt;

  assign filled  = ({1'b0, level} == L_MAX);
  assign drained = (level == '0);

  // Level arithmetic is one bit wider so the fill clamp cannot wrap.
  always_comb begin
    lvl_wide = {1'b0, level};
    lvl_up   = lvl_wide + L_FILL;
    lvl_nxt  = lvl_wide;
    if (fillvalve_on && !drainvalve_on)
      lvl_nxt = (lvl_up > L_MAX) ? L_MAX : lvl_up;
    else if (drainvalve_on && !fillvalve_on)
      lvl_nxt = (lvl_wide < L_DRAIN) ? '0 : lvl_wide - L_DRAIN;
  end

  always_ff @(posedge clk) begin
    if (!rst) level <= '0;
    else      level <= lvl_nxt[LEVEL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst || !motor_on) begin
      cyc_cnt       <= '0;
      cycletime_out <= 1'b0;
    end else if (filled && !cycletime_out) begin
      if (cyc_cnt == CYC_LAST) cycletime_out <= 1'b1;
      else                     cyc_cnt       <= cyc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || !drainvalve_on) begin
      spn_cnt      <= '0;
      spintime_out <= 1'b0;
    end else if (drained && !spintime_out) begin
      if (spn_cnt == SPN_LAST) spintime_out <= 1'b1;
      else                     spn_cnt      <= spn_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (soap_wash && filled) state_nxt = DISPENSE;
      DISPENSE: if (!soap_wash)          state_nxt = IDLE;
                else if (det_cnt == DET_LAST) state_nxt = DONE;
      DONE:     if (!soap_wash)          state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    detergent = 1'b0;
    if (state == DONE) detergent = 1'b1;
  end

  // Counter is zero whenever IDLE, so every entry into DISPENSE starts fresh.
  always_ff @(posedge clk) begin
    if (!rst || state != DISPENSE) det_cnt <= '0;
    else                           det_cnt <= det_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)                           doorclose <= 1'b0;
    else if (user_door_close)           doorclose <= 1'b1;
    else if (user_door_open && !doorlock) doorclose <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) fault <= 1'b0;
    else if ((fillvalve_on && drainvalve_on) || (motor_on && !doorclose))
      fault <= 1'b1;
  end

endmodule

// File: tb/tb_washer_plant_model.sv
// Scoreboard bench for washer_plant_model: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_washer_plant_model;

  localparam int S_FILLED = 0, S_DRAINED = 1, S_DET = 2, S_CTO = 3,
                 S_STO = 4, S_DOOR = 5, S_LEVEL = 6, S_FAULT = 7;

  logic       clk = 1'b0;
  logic       rst, fillvalve_on, drainvalve_on, motor_on, soap_wash, doorlock;
  logic       user_door_close, user_door_open;
  logic       filled, drained, detergent, cycletime_out, spintime_out, doorclose, fault;
  logic [7:0] level;

  typedef struct {
    string nm;
    int    sig;
    int    val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  washer_plant_model dut (
    .clk(clk), .rst(rst),
    .fillvalve_on(fillvalve_on), .drainvalve_on(drainvalve_on),
    .motor_on(motor_on), .soap_wash(soap_wash), .doorlock(doorlock),
    .user_door_close(user_door_close), .user_door_open(user_door_open),
    .filled(filled), .drained(drained), .detergent(detergent),
    .cycletime_out(cycletime_out), .spintime_out(spintime_out),
    .doorclose(doorclose), .level(level), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic int actual(int sig);
    case (sig)
      S_FILLED: return int'(filled);
      S_DRAINED: return int'(drained);
      S_DET:    return int'(detergent);
      S_CTO:    return int'(cycletime_out);
      S_STO:    return int'(spintime_out);
      S_DOOR:   return int'(doorclose);
      S_LEVEL:  return int'(level);
      default:  return int'(fault);
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      int   a;
      e = q.pop_front();
      a = actual(e.sig);
      n_checks++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d at %0t", e.nm, a, e.val, $time);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ex(string nm, int sig, int val);
    q.push_back('{nm, sig, val});
  endtask

  initial begin
    rst = 1'b0; fillvalve_on = 0; drainvalve_on = 0; motor_on = 0;
    soap_wash = 0; doorlock = 0; user_door_close = 0; user_door_open = 0;

    tick(2);
    ex("rst_level", S_LEVEL, 0);   ex("rst_drained", S_DRAINED, 1);
    ex("rst_filled", S_FILLED, 0); ex("rst_det", S_DET, 0);
    ex("rst_cto", S_CTO, 0);       ex("rst_sto", S_STO, 0);
    ex("rst_door", S_DOOR, 0);     ex("rst_fault", S_FAULT, 0);
    rst = 1'b1;

    user_door_close = 1; tick(); user_door_close = 0;
    ex("door_close", S_DOOR, 1);

    // fill ramp: 4 per edge, clamp at 200 on edge 50
    fillvalve_on = 1;
    for (int i = 1; i <= 53; i++) begin
      tick();
      ex("fill_level", S_LEVEL, (4 * i > 200) ? 200 : 4 * i);
      ex("fill_filled", S_FILLED, (i >= 50) ? 1 : 0);
      if (i == 1) ex("fill_drained", S_DRAINED, 0);
    end
    fillvalve_on = 0;

    // detergent: abort after 10 clocks, then full 20-clock dispense
    soap_wash = 1; tick(10); ex("det_abort_pre", S_DET, 0);
    soap_wash = 0; tick(); ex("det_abort", S_DET, 0);
    soap_wash = 1;
    tick(20); ex("det_20", S_DET, 0);
    tick();   ex("det_21", S_DET, 1);
    tick(3);  ex("det_hold", S_DET, 1);
    soap_wash = 0; tick(); ex("det_clear", S_DET, 0);

    // cycle timer with pause: 400 + drain edge + 599 counted edges
    motor_on = 1;
    tick(400); ex("cyc_400", S_CTO, 0); ex("cyc_fault", S_FAULT, 0);
    drainvalve_on = 1; tick(); drainvalve_on = 0;
    ex("cyc_drain_lvl", S_LEVEL, 195); ex("cyc_drain_filled", S_FILLED, 0);
    fillvalve_on = 1; tick(); ex("cyc_refill1", S_LEVEL, 199);
    tick(); ex("cyc_refill2", S_LEVEL, 200); fillvalve_on = 0;
    tick(598); ex("cyc_999", S_CTO, 0);
    tick();    ex("cyc_1000", S_CTO, 1);
    tick(5);   ex("cyc_hold", S_CTO, 1);
    motor_on = 0; tick(); ex("cyc_clear", S_CTO, 0);

    // drain ramp and spin timer
    drainvalve_on = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      ex("drain_level", S_LEVEL, 200 - 5 * i);
      ex("drain_drained", S_DRAINED, (i == 40) ? 1 : 0);
    end
    tick(499); ex("spin_499", S_STO, 0);
    tick();    ex("spin_500", S_STO, 1);
    tick(2);   ex("spin_hold", S_STO, 1);
    drainvalve_on = 0; tick(); ex("spin_clear", S_STO, 0);
    ex("spin_level", S_LEVEL, 0);

    // door lock, close-wins, fault
    doorlock = 1; user_door_open = 1; tick(); user_door_open = 0;
    ex("door_locked", S_DOOR, 1);
    doorlock = 0; user_door_open = 1; tick(); user_door_open = 0;
    ex("door_open", S_DOOR, 0);
    user_door_close = 1; user_door_open = 1; tick();
    user_door_close = 0; user_door_open = 0;
    ex("door_close_wins", S_DOOR, 1);
    user_door_open = 1; tick(); user_door_open = 0;
    ex("door_open2", S_DOOR, 0);
    ex("fault_pre", S_FAULT, 0);
    motor_on = 1; tick(); motor_on = 0; ex("fault_motor", S_FAULT, 1);
    tick(3); ex("fault_sticky", S_FAULT, 1);
    rst = 0; tick(); rst = 1; ex("fault_rst", S_FAULT, 0);
    fillvalve_on = 1; drainvalve_on = 1; tick();
    fillvalve_on = 0; drainvalve_on = 0;
    ex("fault_valves", S_FAULT, 1); ex("fault_valves_lvl", S_LEVEL, 0);

    // mid-operation reset during DISPENSE at level 120
    rst = 0; tick(); rst = 1;
    user_door_close = 1; tick(); user_door_close = 0;
    fillvalve_on = 1; tick(50); fillvalve_on = 0;
    ex("mid_full", S_LEVEL, 200);
    motor_on = 1; soap_wash = 1; tick();
    drainvalve_on = 1; tick(16);
    ex("mid_lvl", S_LEVEL, 120); ex("mid_det", S_DET, 0);
    rst = 0; drainvalve_on = 0; motor_on = 0; soap_wash = 0; tick();
    ex("mid_rst_lvl", S_LEVEL, 0); ex("mid_rst_drained", S_DRAINED, 1);
    ex("mid_rst_det", S_DET, 0);   ex("mid_rst_fault", S_FAULT, 0);
    ex("mid_rst_cto", S_CTO, 0);   ex("mid_rst_door", S_DOOR, 0);
    rst = 1;
    fillvalve_on = 1; tick(50); fillvalve_on = 0;
    soap_wash = 1;
    tick(20); ex("mid_det_20", S_DET, 0);
    tick();   ex("mid_det_21", S_DET, 1);
    ex("mid_end_fault", S_FAULT, 0);
    soap_wash = 0;

    tick(2);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
